// File: rtl/dp_pkg.sv
// Shared types for the parametrised datapath.
// Opcode, shift, writeback-source and sequencer encodings plus status bit positions.
package dp_pkg;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_MVN = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        SH_NONE = 2'b00,
        SH_LSL1 = 2'b01,
        SH_LSR1 = 2'b10,
        SH_ASR1 = 2'b11
    } shift_e;

    typedef enum logic [1:0] {
        VS_C     = 2'b00,
        VS_PC    = 2'b01,
        VS_IMM8  = 2'b10,
        VS_MDATA = 2'b11
    } vsel_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LDA  = 3'd1,
        S_LDB  = 3'd2,
        S_EXEC = 3'd3,
        S_WB   = 3'd4
    } state_e;

    localparam int ST_Z = 0;
    localparam int ST_N = 1;
    localparam int ST_V = 2;

endpackage

// File: rtl/dp_regfile.sv
// Register file: one synchronous write port, one asynchronous read port.
// Synchronous reset clears every entry.
module dp_regfile #(
    parameter  int WIDTH = 16,
    parameter  int NREGS = 8,
    localparam int RW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [RW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [RW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [NREGS];

    // Write port; reset wipes all entries so no stale data survives.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/param_datapath.sv
// Parametrised datapath with an internal sequencer: one start runs a
// whole instruction (read A, read B, execute, write back).
module param_datapath
    import dp_pkg::*;
#(
    parameter  int WIDTH = 16,
    parameter  int NREGS = 8,
    parameter  int PC_W  = 8,
    localparam int RW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [RW-1:0]    rn,
    input  logic [RW-1:0]    rm,
    input  logic [RW-1:0]    rd,
    input  logic [1:0]       alu_op,
    input  logic [1:0]       shift,
    input  logic             asel,
    input  logic             bsel,
    input  logic [1:0]       vsel,
    input  logic             wb_en,
    input  logic             ld_st,
    input  logic [WIDTH-1:0] sximm5,
    input  logic [WIDTH-1:0] sximm8,
    input  logic [WIDTH-1:0] mdata,
    input  logic [PC_W-1:0]  pc,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] datapath_out,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic [2:0]       status
);

    localparam int M = WIDTH - 1;

    state_e           state;
    logic [RW-1:0]    rn_q, rm_q, rd_q;
    alu_op_e          op_q;
    shift_e           sh_q;
    vsel_e            vs_q;
    logic             asel_q, bsel_q, wb_q, ls_q;
    logic [WIDTH-1:0] a_reg, b_reg, c_reg;
    logic [2:0]       st_reg;

    logic [RW-1:0]    raddr;
    logic [WIDTH-1:0] rdata, wdata;
    logic [WIDTH-1:0] sout, ain, bin, sum, diff, res;
    logic             ovf, we;

    assign raddr = (state == S_LDA) ? rn_q : rm_q;
    assign we    = (state == S_WB);

    dp_regfile #(
        .WIDTH (WIDTH),
        .NREGS (NREGS)
    ) u_rf (
        .clk   (clk),
        .reset (reset),
        .we    (we),
        .waddr (rd_q),
        .wdata (wdata),
        .raddr (raddr),
        .rdata (rdata)
    );

    // Shifter on the B register path.
    always_comb begin
        sout = b_reg;
        unique case (sh_q)
            SH_NONE: sout = b_reg;
            SH_LSL1: sout = {b_reg[M-1:0], 1'b0};
            SH_LSR1: sout = {1'b0, b_reg[M:1]};
            SH_ASR1: sout = {b_reg[M], b_reg[M:1]};
        endcase
    end

    assign ain  = asel_q ? '0 : a_reg;
    assign bin  = bsel_q ? sximm5 : sout;
    assign sum  = ain + bin;
    assign diff = ain - bin;

    // ALU result and signed overflow; logic ops never overflow.
    always_comb begin
        res = sum;
        ovf = 1'b0;
        unique case (op_q)
            ALU_ADD: begin
                res = sum;
                ovf = (ain[M] == bin[M]) && (sum[M] != ain[M]);
            end
            ALU_SUB: begin
                res = diff;
                ovf = (ain[M] != bin[M]) && (diff[M] != ain[M]);
            end
            ALU_AND: res = ain & bin;
            ALU_MVN: res = ~bin;
        endcase
    end

    // Writeback source; immediates and memory data are taken live.
    always_comb begin
        wdata = c_reg;
        unique case (vs_q)
            VS_C:     wdata = c_reg;
            VS_PC:    wdata = WIDTH'(pc);
            VS_IMM8:  wdata = sximm8;
            VS_MDATA: wdata = mdata;
        endcase
    end

    // Sequencer: latches the instruction and steps through the pipeline.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            a_reg  <= '0;
            b_reg  <= '0;
            c_reg  <= '0;
            st_reg <= '0;
            rn_q   <= '0;
            rm_q   <= '0;
            rd_q   <= '0;
            op_q   <= ALU_ADD;
            sh_q   <= SH_NONE;
            vs_q   <= VS_C;
            asel_q <= 1'b0;
            bsel_q <= 1'b0;
            wb_q   <= 1'b0;
            ls_q   <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        rn_q   <= rn;
                        rm_q   <= rm;
                        rd_q   <= rd;
                        op_q   <= alu_op_e'(alu_op);
                        sh_q   <= shift_e'(shift);
                        vs_q   <= vsel_e'(vsel);
                        asel_q <= asel;
                        bsel_q <= bsel;
                        wb_q   <= wb_en;
                        ls_q   <= ld_st;
                        if (vsel_e'(vsel) != VS_C) begin
                            if (wb_en) begin
                                state <= S_WB;
                                busy  <= 1'b1;
                            end else begin
                                done  <= 1'b1;
                            end
                        end else begin
                            state <= S_LDA;
                            busy  <= 1'b1;
                        end
                    end
                end
                S_LDA: begin
                    a_reg <= rdata;
                    state <= S_LDB;
                end
                S_LDB: begin
                    b_reg <= rdata;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    c_reg <= res;
                    if (ls_q) begin
                        st_reg[ST_V] <= ovf;
                        st_reg[ST_N] <= res[M];
                        st_reg[ST_Z] <= (res == '0);
                    end
                    if (wb_q) begin
                        state <= S_WB;
                    end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                S_WB: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign datapath_out = c_reg;
    assign a_out        = a_reg;
    assign b_out        = b_reg;
    assign status       = st_reg;

endmodule
